// File: rtl/qpl_paddr_rev_translator_pkg.sv
// Shared QuickPageLite switch-network definitions. The forward decoder and the
// reverse translator both use these functions so the two directions cannot drift.
package qpl_pkg;

  localparam int QPL_MAX_W     = 10;
  localparam int QPL_MAX_NODES = 512;
  localparam int QPL_STG_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } qpl_state_e;

  // Node index of a line in a stage: the line address with bit 'stage' removed.
  function automatic logic [QPL_MAX_W-2:0] qpl_node_idx(
    input logic [QPL_MAX_W-1:0] addr,
    input logic [QPL_STG_W-1:0] stage
  );
    logic [QPL_MAX_W-1:0] low_mask;
    logic [QPL_MAX_W-1:0] high_part;
    low_mask  = ~({QPL_MAX_W{1'b1}} << stage);
    high_part = (addr >> ({1'b0, stage} + 5'd1)) << stage;
    return (QPL_MAX_W-1)'(high_part | (addr & low_mask));
  endfunction

  // One network stage; it is its own inverse because the node index ignores bit 'stage'.
  function automatic logic [QPL_MAX_W-1:0] qpl_stage_apply(
    input logic [QPL_MAX_W-1:0]     addr,
    input logic [QPL_STG_W-1:0]     stage,
    input logic [QPL_MAX_NODES-1:0] scb_row
  );
    logic [QPL_MAX_W-2:0] node;
    logic [QPL_MAX_W-1:0] flip;
    node = qpl_node_idx(addr, stage);
    flip = {{(QPL_MAX_W-1){1'b0}}, scb_row[node]} << stage;
    return addr ^ flip;
  endfunction

endpackage

// File: rtl/qpl_paddr_rev_translator_rev_stage.sv
// Combinational single-stage apply for a BLOCK_D-line network; the stage index
// is an input so one instance can be time-multiplexed across all stages.
module qpl_rev_stage
  import qpl_pkg::*;
#(
  parameter  int BLOCK_D = 128,
  localparam int BLOCK_W = $clog2(BLOCK_D),
  localparam int NODES   = BLOCK_D / 2
) (
  input  logic [BLOCK_W-1:0]   addr,
  input  logic [QPL_STG_W-1:0] stage,
  input  logic [NODES-1:0]     scb_row,
  output logic [BLOCK_W-1:0]   next_addr
);

  logic [QPL_MAX_W-1:0]     addr_ext_s;
  logic [QPL_MAX_W-1:0]     next_ext_s;
  logic [QPL_MAX_NODES-1:0] row_ext_s;
  logic                     unused_s;

  assign addr_ext_s = QPL_MAX_W'(addr);
  assign row_ext_s  = QPL_MAX_NODES'(scb_row);
  assign next_ext_s = qpl_stage_apply(addr_ext_s, stage, row_ext_s);
  assign next_addr  = next_ext_s[BLOCK_W-1:0];
  // Upper bits stay zero for narrow blocks.
  assign unused_s   = ^next_ext_s;

endmodule

// File: rtl/qpl_paddr_rev_translator.sv
// Reverse (physical-to-virtual) line translator: walks the switch network from the
// last stage back to stage 0, one stage per clock, with valid/ready on both sides.
module qpl_paddr_rev_translator
  import qpl_pkg::*;
#(
  parameter  int BLOCK_D = 128,
  parameter  int TAG_W   = 8,
  parameter  int SNAP_EN = 1,
  localparam int BLOCK_W = $clog2(BLOCK_D),
  localparam int NODES   = BLOCK_D / 2,
  localparam int STAGES  = $clog2(BLOCK_D)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [STAGES-1:0][NODES-1:0]  i_scb,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [BLOCK_W-1:0]            i_paddr_line,
  input  logic [TAG_W-1:0]              i_tag,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [BLOCK_W-1:0]            o_vaddr_line,
  output logic [TAG_W-1:0]              o_tag
);

  localparam int               CNT_W    = $clog2(STAGES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  qpl_state_e                  state_r, state_s;
  logic [CNT_W-1:0]            cnt_r, cnt_s;
  logic [BLOCK_W-1:0]          addr_r, addr_s;
  logic [TAG_W-1:0]            tag_r, tag_s;
  logic                        valid_r, valid_s;
  logic                        ready_r, ready_s;
  logic                        snap_ld_s;
  logic [STAGES-1:0][NODES-1:0] snap_r;
  logic [STAGES-1:0][NODES-1:0] scb_use_s;
  logic [NODES-1:0]            scb_row_s;
  logic [BLOCK_W-1:0]          stage_next_s;

  assign scb_use_s = (SNAP_EN != 0) ? snap_r : i_scb;
  assign scb_row_s = scb_use_s[cnt_r];

  qpl_rev_stage #(
    .BLOCK_D (BLOCK_D)
  ) u_stage (
    .addr      (addr_r),
    .stage     (QPL_STG_W'(cnt_r)),
    .scb_row   (scb_row_s),
    .next_addr (stage_next_s)
  );

  // Next-state and next-datapath logic for the IDLE/WALK/DONE walk.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    tag_s     = tag_r;
    valid_s   = valid_r;
    ready_s   = ready_r;
    snap_ld_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_valid && ready_r) begin
          addr_s    = i_paddr_line;
          tag_s     = i_tag;
          snap_ld_s = (SNAP_EN != 0);
          cnt_s     = CNT_LAST;
          state_s   = WALK;
          ready_s   = 1'b0;
        end else begin
          ready_s = 1'b1;
        end
      end
      WALK: begin
        addr_s = stage_next_s;
        if (cnt_r == CNT_ZERO) begin
          state_s = DONE;
          valid_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      DONE: begin
        if (valid_r && i_ready) begin
          state_s = IDLE;
          valid_s = 1'b0;
          ready_s = 1'b1;
        end else begin
          valid_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      addr_r  <= {BLOCK_W{1'b0}};
      tag_r   <= {TAG_W{1'b0}};
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      tag_r   <= tag_s;
      valid_r <= valid_s;
      ready_r <= ready_s;
    end
  end

  // Switch-control snapshot taken at accept; deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (snap_ld_s && !i_rst) begin
      snap_r <= i_scb;
    end
  end

  assign o_ready      = ready_r;
  assign o_valid      = valid_r;
  assign o_vaddr_line = addr_r;
  assign o_tag        = tag_r;

endmodule

// File: tb/tb_qpl_paddr_rev_translator.sv
// Bench for the reverse translator: directed BLOCK_D=8 cases plus a BLOCK_D=128
// random round-trip sweep, all checked against a brute-force inverse of the network.
module tb_qpl_paddr_rev_translator;

  localparam int SA = 3, NA = 4, SB = 7, NB = 64, TW = 8;

  typedef logic [SB-1:0][NB-1:0] scb_t;
  typedef logic [SA-1:0][NA-1:0] scb8_t;
  typedef struct {int p; int v; int tag; scb_t scb;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  scb8_t a_scb;
  logic a_valid, a_ready, a_ovalid, a_iready;
  logic [SA-1:0] a_paddr, a_vaddr;
  logic [TW-1:0] a_tag, a_otag;
  scb_t b_scb;
  logic b_valid, b_ready, b_ovalid, b_iready;
  logic [SB-1:0] b_paddr, b_vaddr;
  logic [TW-1:0] b_tag, b_otag;

  qpl_paddr_rev_translator #(.BLOCK_D(8), .TAG_W(TW), .SNAP_EN(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_scb(a_scb), .i_valid(a_valid), .o_ready(a_ready),
    .i_paddr_line(a_paddr), .i_tag(a_tag), .o_valid(a_ovalid), .i_ready(a_iready),
    .o_vaddr_line(a_vaddr), .o_tag(a_otag));

  qpl_paddr_rev_translator #(.BLOCK_D(128), .TAG_W(TW), .SNAP_EN(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_scb(b_scb), .i_valid(b_valid), .o_ready(b_ready),
    .i_paddr_line(b_paddr), .i_tag(b_tag), .o_valid(b_ovalid), .i_ready(b_iready),
    .o_vaddr_line(b_vaddr), .o_tag(b_otag));

  int n_vec = 0, n_fail = 0;
  exp_t qa[$], qb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: event occurred or bound expired, required otherwise", name);
  endtask

  // Forward network straight from the definition, on plain integers.
  function automatic int fwd(input int a, input scb_t scb, input int st);
    int v;
    v = a;
    for (int s = 0; s < st; s++) begin
      int n;
      n = ((v >> (s + 1)) << s) | (v & ((1 << s) - 1));
      if (scb[s][n]) v = v ^ (1 << s);
    end
    return v;
  endfunction

  // Reverse by exhaustive search: the virtual line whose forward image is p.
  function automatic int rev_model(input int p, input scb_t scb, input int st);
    for (int v = 0; v < (1 << st); v++)
      if (fwd(v, scb, st) == p) return v;
    return -1;
  endfunction

  function automatic scb_t widen(input scb8_t s);
    scb_t w;
    w = '0;
    for (int i = 0; i < SA; i++)
      for (int j = 0; j < NA; j++) w[i][j] = s[i][j];
    return w;
  endfunction

  task automatic send_a(input int p, input int t, input scb8_t s, input bit push, output int acc);
    int k;
    a_paddr = p[SA-1:0];
    a_tag   = t[TW-1:0];
    a_scb   = s;
    a_valid = 1'b1;
    k = 0;
    while (!a_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!a_ready) fail("a_accept_timeout");
    @(posedge clk); #1;
    acc = cyc;
    a_valid = 1'b0;
    if (push) qa.push_back('{p, rev_model(p, widen(s), SA), t, widen(s)});
  endtask

  task automatic wait_valid_a(output int lat);
    lat = 0;
    while (!a_ovalid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!a_ovalid) fail("a_valid_timeout");
  endtask

  task automatic run_b(input int p, input int t, input scb_t s);
    int k;
    b_paddr = p[SB-1:0];
    b_tag   = t[TW-1:0];
    b_scb   = s;
    b_valid = 1'b1;
    k = 0;
    while (!b_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!b_ready) fail("b_accept_timeout");
    @(posedge clk); #1;
    b_valid = 1'b0;
    qb.push_back('{p, rev_model(p, s, SB), t, s});
    k = 0;
    while (!b_ovalid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!b_ovalid) fail("b_valid_timeout");
    @(posedge clk); #1;
  endtask

  // Compare process: checks every consumer handshake and every stalled cycle.
  initial begin
    exp_t e;
    logic pa_valid, pa_ready;
    int pa_v, pa_t;
    pa_valid = 1'b0; pa_ready = 1'b1; pa_v = 0; pa_t = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pa_valid = 1'b0;
      end else begin
        if (pa_valid && !pa_ready) begin
          chk("stall_valid", int'(a_ovalid), 1);
          chk("stall_vaddr", int'(a_vaddr), pa_v);
          chk("stall_tag", int'(a_otag), pa_t);
          chk("stall_ready", int'(a_ready), 0);
        end
        if (a_ovalid && a_iready) begin
          if (qa.size() == 0) fail("a_spurious_result");
          else begin
            e = qa.pop_front();
            chk("a_vaddr", int'(a_vaddr), e.v);
            chk("a_tag", int'(a_otag), e.tag);
          end
        end
        if (b_ovalid && b_iready) begin
          if (qb.size() == 0) fail("b_spurious_result");
          else begin
            e = qb.pop_front();
            chk("b_vaddr", int'(b_vaddr), e.v);
            chk("b_tag", int'(b_otag), e.tag);
            chk("b_roundtrip", fwd(int'(b_vaddr), e.scb, SB), e.p);
          end
        end
        pa_valid = a_ovalid; pa_ready = a_iready;
        pa_v = int'(a_vaddr); pa_t = int'(a_otag);
      end
    end
  end

  initial begin
    scb8_t scb0, scb2, scb3;
    scb_t rs;
    int lat, c1, c2;
    scb0 = '0;
    scb2 = '0; scb2[0] = 4'b1111;
    scb3 = '0; scb3[2][2] = 1'b1; scb3[1][0] = 1'b1;
    rst = 1'b1;
    a_scb = '0; a_valid = 1'b0; a_paddr = '0; a_tag = '0; a_iready = 1'b1;
    b_scb = '0; b_valid = 1'b0; b_paddr = '0; b_tag = '0; b_iready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(a_ovalid), 0);
    chk("rst_ready", int'(a_ready), 1);
    chk("rst_vaddr", int'(a_vaddr), 0);
    chk("rst_tag", int'(a_otag), 0);
    rst = 1'b0;

    // Model pinned against hand-derived values.
    chk("model_rev_t2", rev_model(5, widen(scb2), SA), 4);
    chk("model_rev_t3", rev_model(6, widen(scb3), SA), 0);
    chk("model_fwd_t3", fwd(0, widen(scb3), SA), 6);

    @(posedge clk); #1;
    send_a(5, 8'h3c, scb0, 1'b1, c1);
    wait_valid_a(lat);
    chk("t1_latency", lat, 3);
    chk("t1_vaddr", int'(a_vaddr), 5);
    chk("t1_tag", int'(a_otag), 8'h3c);
    @(posedge clk); #1;

    send_a(5, 8'h11, scb2, 1'b1, c1);
    wait_valid_a(lat);
    chk("t2_vaddr_p5", int'(a_vaddr), 4);
    @(posedge clk); #1;
    send_a(2, 8'h22, scb2, 1'b1, c1);
    wait_valid_a(lat);
    chk("t2_vaddr_p2", int'(a_vaddr), 3);
    @(posedge clk); #1;

    send_a(6, 8'h33, scb3, 1'b1, c1);
    wait_valid_a(lat);
    chk("t3_vaddr", int'(a_vaddr), 0);
    @(posedge clk); #1;

    send_a(6, 8'h44, scb3, 1'b1, c1);
    a_scb = ~scb3;
    wait_valid_a(lat);
    chk("t4_snapshot_vaddr", int'(a_vaddr), 0);
    @(posedge clk); #1;
    a_scb = scb0;

    a_iready = 1'b0;
    send_a(3, 8'h55, scb2, 1'b1, c1);
    wait_valid_a(lat);
    repeat (10) begin
      @(posedge clk); #1;
      chk("t5_hold_valid", int'(a_ovalid), 1);
      chk("t5_hold_ready", int'(a_ready), 0);
    end
    a_iready = 1'b1;
    @(posedge clk); #1;
    chk("t5_ready_after", int'(a_ready), 1);
    chk("t5_valid_after", int'(a_ovalid), 0);
    send_a(7, 8'h66, scb3, 1'b1, c1);
    send_a(1, 8'h77, scb2, 1'b1, c2);
    chk("t5_interval", c2 - c1, SA + 2);
    wait_valid_a(lat);
    @(posedge clk); #1;

    send_a(6, 8'ha5, scb2, 1'b0, c1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rst_valid", int'(a_ovalid), 0);
    chk("t6_rst_ready", int'(a_ready), 1);
    chk("t6_rst_vaddr", int'(a_vaddr), 0);
    chk("t6_rst_tag", int'(a_otag), 0);
    repeat (12) @(posedge clk);
    #1;

    for (int i = 0; i < 1000; i++) begin
      for (int s = 0; s < SB; s++) rs[s] = {$urandom, $urandom};
      run_b(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)), rs);
    end

    repeat (3) @(posedge clk);
    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
